// File: rtl/sync_dualport_ram_pkg.sv
// Shared constants for the simple dual-port scratch RAM.
// Default word width, depth and address width used by the RAM top.
package sync_dualport_ram_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

endpackage

// File: rtl/sync_dualport_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Reads see the contents from before the same edge's write (read-first).
module sync_dualport_ram
    import sync_dualport_ram_pkg::*;
#(
    parameter int width     = DATA_W,
    parameter int depth     = DEPTH,
    parameter int addr_size = ADDR_W
) (
    input  logic [width-1:0]     data_in,
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [addr_size-1:0] wr_addr,
    input  logic [addr_size-1:0] rd_addr,
    output logic [width-1:0]     data_out
);

    logic [depth-1:0][width-1:0] mem_q;
    logic [depth-1:0][width-1:0] mem_d;
    logic [width-1:0]            dout_q;
    logic [width-1:0]            dout_d;

    // Read samples mem_q, so a same-address write lands only on the next read.
    always_comb begin
        mem_d  = mem_q;
        dout_d = dout_q;
        if (wr_en) begin
            mem_d[wr_addr] = data_in;
        end
        if (rd_en) begin
            dout_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            dout_q <= '0;
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
        end
    end

    assign data_out = dout_q;

endmodule

// File: tb/tb_sync_dualport_ram.sv
// Randomized and directed bench for sync_dualport_ram.
// A word-array model is compared with data_out on every falling edge.
module tb_sync_dualport_ram;

    localparam int W = 8;
    localparam int D = 16;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic         rd_en;
    logic [A-1:0] wr_addr;
    logic [A-1:0] rd_addr;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] model_mem [D];
    logic [W-1:0] model_out;
    bit           model_known = 1'b0;

    sync_dualport_ram #(
        .width     (W),
        .depth     (D),
        .addr_size (A)
    ) dut (
        .data_in  (data_in),
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Reference: reset clears everything; a read returns the word
    // as it stood before this edge; then the write is applied.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) model_mem[i] = '0;
            model_out   = '0;
            model_known = 1'b1;
        end else begin
            if (rd_en) model_out = model_mem[rd_addr];
            if (wr_en) model_mem[wr_addr] = data_in;
        end
    end

    always @(negedge clk) begin
        if (model_known) begin
            checks++;
            if (data_out !== model_out) begin
                errors++;
                $display("FAIL model t=%0t got=%0d want=%0d",
                         $time, data_out, model_out);
            end
        end
    end

    task automatic cyc(input bit r, input bit we, input bit re,
                       input int wa, input int ra, input int din);
        rst     = r;
        wr_en   = we;
        rd_en   = re;
        wr_addr = A'(wa);
        rd_addr = A'(ra);
        data_in = W'(din);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input int want);
        checks++;
        if (data_out !== W'(want)) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, data_out, want);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; data_in = '0;
        @(negedge clk);

        cyc(1, 0, 1, 0, 11, 0);   expect_lit("reset_out", 0);
        cyc(0, 0, 1, 0, 11, 0);   expect_lit("read_after_reset", 0);

        cyc(0, 1, 0, 13, 0, 200); expect_lit("write_no_read", 0);
        cyc(0, 0, 1, 0, 13, 0);   expect_lit("readback_13", 200);

        cyc(0, 1, 1, 9, 13, 50);  expect_lit("concurrent_rd13", 200);
        cyc(0, 0, 1, 0, 9, 0);    expect_lit("readback_9", 50);

        cyc(0, 0, 0, 0, 1, 0);    expect_lit("rd_disabled_hold", 50);
        cyc(0, 1, 0, 0, 1, 10);   expect_lit("hold_during_wr", 50);
        cyc(0, 0, 1, 0, 0, 0);    expect_lit("readback_0", 10);

        cyc(0, 1, 0, 6, 0, 140);
        cyc(0, 1, 1, 6, 6, 77);   expect_lit("collision_old", 140);
        cyc(0, 0, 1, 0, 6, 0);    expect_lit("collision_new", 77);

        cyc(0, 0, 0, 1, 0, 70);
        cyc(0, 0, 1, 0, 1, 0);    expect_lit("wr_disabled", 0);

        cyc(1, 1, 1, 3, 6, 99);   expect_lit("reset_priority", 0);
        cyc(0, 0, 1, 0, 3, 0);    expect_lit("reset_drops_wr", 0);
        cyc(0, 0, 1, 0, 6, 0);    expect_lit("reset_clears_6", 0);

        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 49) == 0),
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, D - 1),
                $urandom_range(0, D - 1),
                $urandom_range(0, 255));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
